// File: rtl/router_pkg.sv
// Shared definitions for the output-port-lookup rewrite stages: header field
// offsets in the 256-bit first beat, legal output-queue codes, FSM states.
package router_pkg;

    localparam int unsigned MAC_W    = 48;
    localparam int unsigned DMAC_LSB = 208;
    localparam int unsigned SMAC_LSB = 160;
    localparam int unsigned TTL_LSB  = 72;
    localparam int unsigned TTL_W    = 8;
    localparam int unsigned CSUM_LSB = 48;
    localparam int unsigned CSUM_W   = 16;

    localparam logic [7:0] OQ_NF0 = 8'h01;
    localparam logic [7:0] OQ_NF1 = 8'h04;
    localparam logic [7:0] OQ_NF2 = 8'h10;
    localparam logic [7:0] OQ_NF3 = 8'h40;

    typedef enum logic {
        WAIT_SOP = 1'b0,
        IN_PKT   = 1'b1
    } st_t;

    // NF port one-hots sit on even bits; the matching CPU queue is the next bit up.
    function automatic logic [7:0] cpu_port(input logic [7:0] src_onehot);
        return src_onehot << 1;
    endfunction

    function automatic logic oq_legal(input logic [7:0] oq);
        return (oq == OQ_NF0) || (oq == OQ_NF1) || (oq == OQ_NF2) || (oq == OQ_NF3);
    endfunction

endpackage

// File: rtl/router_hdr_rewrite_if.sv
// AXI-Stream bundle used between the lookup pipeline stages.
interface router_hdr_rewrite_if #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned USER_W = 128
) ();

    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [USER_W-1:0]   tuser;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );

endinterface

// File: rtl/ip_csum_ttl_dec.sv
// Incremental IPv4 header checksum update for a TTL decrement by one:
// ones-complement add of 0x0100 with the end-around carry folded back in.
module ip_csum_ttl_dec
    import router_pkg::*;
(
    input  logic [CSUM_W-1:0] csum_i,
    output logic [CSUM_W-1:0] csum_o
);

    logic [CSUM_W:0] sum;

    always_comb begin
        sum    = {1'b0, csum_i} + {1'b0, 16'h0100};
        csum_o = sum[CSUM_W-1:0] + {{(CSUM_W-1){1'b0}}, sum[CSUM_W]};
    end

endmodule

// File: rtl/router_hdr_rewrite.sv
// Rewrites the first beat of each routed IPv4 packet (MACs, TTL, checksum,
// TUSER destination) behind a single output register stage.
module router_hdr_rewrite
    import router_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned DST_PORT_POS         = 24
) (
    input  logic                        AXI_ACLK,
    input  logic                        AXI_RESET,
    router_hdr_rewrite_if.slave         s_axis,
    router_hdr_rewrite_if.master        m_axis,
    input  logic                        arp_hit,
    input  logic [MAC_W-1:0]            dest_mac,
    input  logic [31:0]                 oq_reg_out,
    input  logic [MAC_W-1:0]            mac0,
    input  logic [MAC_W-1:0]            mac1,
    input  logic [MAC_W-1:0]            mac2,
    input  logic [MAC_W-1:0]            mac3,
    output logic [31:0]                 forwarded_count,
    output logic [31:0]                 arp_miss_count,
    output logic [31:0]                 ttl_expired_count
);

    localparam int unsigned DW  = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned SW  = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned UW  = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned SUW = C_S_AXIS_TUSER_WIDTH;

    st_t               state_q, state_d;
    logic [DW-1:0]     tdata_q, tdata_d;
    logic [DW/8-1:0]   tstrb_q, tstrb_d;
    logic [UW-1:0]     tuser_q, tuser_d;
    logic              tlast_q, tlast_d;
    logic              tvalid_q, tvalid_d;
    logic [31:0]       fwd_q, fwd_d;
    logic [31:0]       miss_q, miss_d;
    logic [31:0]       ttl_exp_q, ttl_exp_d;

    logic [SW-1:0]     in_data;
    logic [SW/8-1:0]   in_strb;
    logic [SUW-1:0]    in_user;
    logic              s_ready;
    logic              accept;
    logic [7:0]        src_oh;
    logic [7:0]        dst_oh;
    logic [7:0]        oq;
    logic [TTL_W-1:0]  ttl;
    logic [CSUM_W-1:0] csum_new;
    logic [MAC_W-1:0]  router_mac;
    logic              unused_oq_hi;

    assign in_data  = s_axis.tdata;
    assign in_strb  = s_axis.tstrb;
    assign in_user  = s_axis.tuser;
    assign s_ready  = !tvalid_q || m_axis.tready;
    assign accept   = s_axis.tvalid && s_ready;
    assign src_oh   = in_user[SRC_PORT_POS +: 8];
    assign dst_oh   = in_user[DST_PORT_POS +: 8];
    assign oq       = oq_reg_out[7:0];
    assign ttl      = in_data[TTL_LSB +: TTL_W];
    assign unused_oq_hi = ^oq_reg_out[31:8];

    assign s_axis.tready = s_ready;

    ip_csum_ttl_dec u_csum (
        .csum_i (in_data[CSUM_LSB +: CSUM_W]),
        .csum_o (csum_new)
    );

    always_comb begin
        router_mac = mac0;
        case (oq)
            OQ_NF1:  router_mac = mac1;
            OQ_NF2:  router_mac = mac2;
            OQ_NF3:  router_mac = mac3;
            default: router_mac = mac0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        tdata_d   = tdata_q;
        tstrb_d   = tstrb_q;
        tuser_d   = tuser_q;
        tlast_d   = tlast_q;
        tvalid_d  = tvalid_q && !m_axis.tready;
        fwd_d     = fwd_q;
        miss_d    = miss_q;
        ttl_exp_d = ttl_exp_q;

        if (accept) begin
            tvalid_d = 1'b1;
            tdata_d  = in_data;
            tstrb_d  = in_strb;
            tuser_d  = in_user;
            tlast_d  = s_axis.tlast;
            case (state_q)
                WAIT_SOP: begin
                    if (!s_axis.tlast) begin
                        state_d = IN_PKT;
                    end
                    // Priority: already-routed, then miss/illegal/single-beat, then TTL, then forward.
                    if (dst_oh != 8'h00) begin
                        tuser_d = in_user;
                    end else if (s_axis.tlast || !arp_hit || !oq_legal(oq)) begin
                        tuser_d[DST_PORT_POS +: 8] = cpu_port(src_oh);
                        if (!s_axis.tlast) begin
                            miss_d = miss_q + 32'd1;
                        end
                    end else if (ttl <= 8'd1) begin
                        tuser_d[DST_PORT_POS +: 8] = cpu_port(src_oh);
                        ttl_exp_d = ttl_exp_q + 32'd1;
                    end else begin
                        tdata_d[DMAC_LSB +: MAC_W]  = dest_mac;
                        tdata_d[SMAC_LSB +: MAC_W]  = router_mac;
                        tdata_d[TTL_LSB +: TTL_W]   = ttl - 8'd1;
                        tdata_d[CSUM_LSB +: CSUM_W] = csum_new;
                        tuser_d[DST_PORT_POS +: 8]  = oq;
                        fwd_d = fwd_q + 32'd1;
                    end
                end
                IN_PKT: begin
                    if (s_axis.tlast) begin
                        state_d = WAIT_SOP;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge AXI_ACLK) begin
        if (AXI_RESET) begin
            state_q   <= WAIT_SOP;
            tdata_q   <= '0;
            tstrb_q   <= '0;
            tuser_q   <= '0;
            tlast_q   <= 1'b0;
            tvalid_q  <= 1'b0;
            fwd_q     <= '0;
            miss_q    <= '0;
            ttl_exp_q <= '0;
        end else begin
            state_q   <= state_d;
            tdata_q   <= tdata_d;
            tstrb_q   <= tstrb_d;
            tuser_q   <= tuser_d;
            tlast_q   <= tlast_d;
            tvalid_q  <= tvalid_d;
            fwd_q     <= fwd_d;
            miss_q    <= miss_d;
            ttl_exp_q <= ttl_exp_d;
        end
    end

    assign m_axis.tdata  = tdata_q;
    assign m_axis.tstrb  = tstrb_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tvalid = tvalid_q;

    assign forwarded_count   = fwd_q;
    assign arp_miss_count    = miss_q;
    assign ttl_expired_count = ttl_exp_q;

endmodule

// File: tb/tb_router_hdr_rewrite.sv
// Directed bench for router_hdr_rewrite: a packet-level reference model fills an
// expected-beat queue that one compare process checks at every output handshake.
module tb_router_hdr_rewrite;

    logic        clk = 1'b0;
    logic        rst;
    logic        arp_hit;
    logic [47:0] dest_mac;
    logic [31:0] oq;
    logic [47:0] mac0, mac1, mac2, mac3;
    logic [31:0] fwd_cnt, miss_cnt, ttl_cnt;

    always #5 clk = ~clk;

    router_hdr_rewrite_if #(.DATA_W(256), .USER_W(128)) s_if ();
    router_hdr_rewrite_if #(.DATA_W(256), .USER_W(128)) m_if ();

    router_hdr_rewrite #(
        .C_M_AXIS_DATA_WIDTH  (256),
        .C_S_AXIS_DATA_WIDTH  (256),
        .C_M_AXIS_TUSER_WIDTH (128),
        .C_S_AXIS_TUSER_WIDTH (128),
        .SRC_PORT_POS         (16),
        .DST_PORT_POS         (24)
    ) dut (
        .AXI_ACLK          (clk),
        .AXI_RESET         (rst),
        .s_axis            (s_if),
        .m_axis            (m_if),
        .arp_hit           (arp_hit),
        .dest_mac          (dest_mac),
        .oq_reg_out        (oq),
        .mac0              (mac0),
        .mac1              (mac1),
        .mac2              (mac2),
        .mac3              (mac3),
        .forwarded_count   (fwd_cnt),
        .arp_miss_count    (miss_cnt),
        .ttl_expired_count (ttl_cnt)
    );

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        logic [127:0] u;
        logic         l;
    } beat_t;

    beat_t       expq[$];
    beat_t       prev, e;
    bit          prev_stall = 1'b0;
    int unsigned m_fwd = 0, m_miss = 0, m_ttl = 0;
    bit          m_in_pkt = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what the rewritten beat must look like, from packet rules.
    function automatic beat_t model(input beat_t b);
        beat_t  r;
        int     csum;
        logic [7:0] src, dst, ttl;
        logic [47:0] smac;
        bit legal;
        r = b;
        if (!m_in_pkt) begin
            src   = b.u[23:16];
            dst   = b.u[31:24];
            ttl   = b.d[79:72];
            legal = (oq[7:0] == 8'h01) || (oq[7:0] == 8'h04) || (oq[7:0] == 8'h10) || (oq[7:0] == 8'h40);
            if (dst != 0) begin
                r = b;
            end else if (b.l || !arp_hit || !legal) begin
                r.u[31:24] = 8'(src * 2);
                if (!b.l) m_miss++;
            end else if (ttl < 2) begin
                r.u[31:24] = 8'(src * 2);
                m_ttl++;
            end else begin
                if (oq[7:0] == 8'h01) smac = mac0;
                else if (oq[7:0] == 8'h04) smac = mac1;
                else if (oq[7:0] == 8'h10) smac = mac2;
                else smac = mac3;
                csum = int'(b.d[63:48]) + 256;
                if (csum > 65535) csum = csum - 65535;
                r.d[255:208] = dest_mac;
                r.d[207:160] = smac;
                r.d[79:72]   = ttl - 8'd1;
                r.d[63:48]   = 16'(csum);
                r.u[31:24]   = oq[7:0];
                m_fwd++;
            end
        end
        m_in_pkt = !b.l;
        return r;
    endfunction

    task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l,
                             input logic [31:0] st);
        bit    acc;
        int    n;
        beat_t b;
        s_if.tdata  = d;
        s_if.tuser  = u;
        s_if.tlast  = l;
        s_if.tstrb  = st;
        s_if.tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_if.tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no S_AXIS_TREADY in %0d cycles, required within 50", n);
        end else begin
            b.d = d; b.u = u; b.l = l; b.s = st;
            expq.push_back(model(b));
        end
    endtask

    task automatic idle(input int n);
        s_if.tvalid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [255:0] mk_hdr(input logic [31:0] seed, input logic [7:0] ttl,
                                           input logic [15:0] csum);
        logic [255:0] d;
        d = {8{seed}};
        d[79:72] = ttl;
        d[63:48] = csum;
        return d;
    endfunction

    function automatic logic [127:0] mk_user(input logic [7:0] src, input logic [7:0] dst);
        logic [127:0] u;
        u = {4{32'h5A5A_C3C3}};
        u[23:16] = src;
        u[31:24] = dst;
        return u;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_fwd"},  fwd_cnt,  m_fwd);
        check({tag, "_miss"}, miss_cnt, m_miss);
        check({tag, "_ttl"},  ttl_cnt,  m_ttl);
    endtask

    // Compare process: every output handshake against the model queue, plus hold-stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", m_if.tvalid, 1'b1);
                check("hold_data",  m_if.tdata,  prev.d);
                check("hold_user",  m_if.tuser,  prev.u);
                check("hold_last",  m_if.tlast,  prev.l);
            end
            if (m_if.tvalid && m_if.tready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL extra_beat: got beat %h with nothing expected", m_if.tdata);
                end else begin
                    e = expq.pop_front();
                    check("out_data", m_if.tdata, e.d);
                    check("out_user", m_if.tuser, e.u);
                    check("out_strb", m_if.tstrb, e.s);
                    check("out_last", m_if.tlast, e.l);
                end
            end
            prev_stall = m_if.tvalid && !m_if.tready;
            prev.d = m_if.tdata;
            prev.u = m_if.tuser;
            prev.l = m_if.tlast;
        end
    end

    logic [255:0] d0;
    int           spins;

    initial begin
        rst = 1'b1;
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0; s_if.tstrb = '0;
        m_if.tready = 1'b1;
        arp_hit  = 1'b0;
        dest_mac = 48'h0011_2233_4455;
        oq       = 32'h0;
        mac0 = 48'h0200_0000_0001;
        mac1 = 48'h0A0B_0C0D_0E0F;
        mac2 = 48'h0200_0000_0003;
        mac3 = 48'h0200_0000_0004;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", m_if.tvalid, 1'b0);
        check("rst_data",  m_if.tdata,  '0);
        check("rst_user",  m_if.tuser,  '0);
        check("rst_fwd",   fwd_cnt,     32'd0);
        check("rst_miss",  miss_cnt,    32'd0);
        check("rst_ttl",   ttl_cnt,     32'd0);
        rst = 1'b0;
        idle(1);

        // 1. Forward via oq 0x04 -> mac1.
        arp_hit = 1'b1; oq = 32'h0000_0004;
        send_beat(mk_hdr(32'h1111_2222, 8'h40, 16'hB1E6), mk_user(8'h01, 8'h00), 1'b0, '1);
        check("t1_dmac", m_if.tdata[255:208], 48'h0011_2233_4455);
        check("t1_smac", m_if.tdata[207:160], 48'h0A0B_0C0D_0E0F);
        check("t1_ttl",  m_if.tdata[79:72],   8'h3F);
        check("t1_csum", m_if.tdata[63:48],   16'hB2E6);
        check("t1_dst",  m_if.tuser[31:24],   8'h04);
        arp_hit = 1'b0; oq = 32'h0;
        send_beat({8{32'hDEAD_BEEF}}, mk_user(8'h01, 8'h00), 1'b1, 32'h0000_FFFF);
        idle(2);
        check("t1_fwd_lit", fwd_cnt, 32'd1);
        check_counts("t1");

        // 2. Checksum carry fold, both corner values.
        arp_hit = 1'b1; oq = 32'hFFFF_FF01;
        send_beat(mk_hdr(32'h3333_4444, 8'h05, 16'hFF00), mk_user(8'h04, 8'h00), 1'b0, '1);
        check("t2_csum", m_if.tdata[63:48], 16'h0001);
        check("t2_ttl",  m_if.tdata[79:72], 8'h04);
        check("t2_smac", m_if.tdata[207:160], 48'h0200_0000_0001);
        send_beat({8{32'h0101_0101}}, mk_user(8'h04, 8'h00), 1'b1, '1);
        oq = 32'h0000_0040;
        send_beat(mk_hdr(32'h5555_6666, 8'hFF, 16'hFFFF), mk_user(8'h40, 8'h00), 1'b0, '1);
        check("t2_csum_ffff", m_if.tdata[63:48], 16'h0100);
        check("t2_ttl_ff",    m_if.tdata[79:72], 8'hFE);
        send_beat({8{32'h0202_0202}}, mk_user(8'h40, 8'h00), 1'b1, '1);
        idle(2);
        check_counts("t2");

        // 3. ARP miss, illegal oq, TTL expiry.
        arp_hit = 1'b0; oq = 32'h0000_0010;
        d0 = mk_hdr(32'h7777_8888, 8'h40, 16'h1234);
        send_beat(d0, mk_user(8'h10, 8'h00), 1'b0, '1);
        check("t3_miss_data", m_if.tdata, d0);
        check("t3_miss_dst",  m_if.tuser[31:24], 8'h20);
        send_beat({8{32'h0303_0303}}, mk_user(8'h10, 8'h00), 1'b1, '1);
        idle(1);
        check("t3_miss_lit", miss_cnt, 32'd1);
        arp_hit = 1'b1; oq = 32'h0000_0002;
        send_beat(d0, mk_user(8'h10, 8'h00), 1'b0, '1);
        send_beat({8{32'h0404_0404}}, mk_user(8'h10, 8'h00), 1'b1, '1);
        oq = 32'h0000_0010;
        send_beat(mk_hdr(32'h9999_AAAA, 8'h01, 16'h4321), mk_user(8'h10, 8'h00), 1'b0, '1);
        check("t3_ttl_dst", m_if.tuser[31:24], 8'h20);
        send_beat(mk_hdr(32'h0505_0505, 8'h00, 16'h0000), mk_user(8'h10, 8'h00), 1'b1, '1);
        idle(2);
        check("t3_ttl_lit",  ttl_cnt,  32'd1);
        check("t3_miss2_lit", miss_cnt, 32'd2);
        check_counts("t3");

        // 4. Backpressure across a 4-beat packet.
        oq = 32'h0000_0004;
        fork
            begin
                send_beat(mk_hdr(32'hABCD_0001, 8'h20, 16'h0F0F), mk_user(8'h01, 8'h00), 1'b0, '1);
                send_beat({8{32'hABCD_0002}}, mk_user(8'h01, 8'h00), 1'b0, '1);
                send_beat({8{32'hABCD_0003}}, mk_user(8'h01, 8'h00), 1'b0, '1);
                send_beat({8{32'hABCD_0004}}, mk_user(8'h01, 8'h00), 1'b1, 32'h00FF_FFFF);
            end
            begin
                @(posedge clk);
                #1;
                m_if.tready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("t4_s_tready", s_if.tready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                m_if.tready = 1'b1;
            end
        join
        idle(3);
        check("t4_drained", expq.size(), 0);
        check_counts("t4");

        // 5. Pre-routed packet passes untouched, sideband ignored.
        arp_hit = 1'b1; oq = 32'h0000_0004;
        d0 = mk_hdr(32'hCAFE_F00D, 8'h40, 16'hB1E6);
        send_beat(d0, mk_user(8'h01, 8'h02), 1'b0, '1);
        check("t5_data", m_if.tdata, d0);
        send_beat({8{32'h0606_0606}}, mk_user(8'h01, 8'h02), 1'b1, '1);
        idle(2);
        check_counts("t5");

        // 6. Back-to-back 2-beat then single-beat, then reset mid-packet.
        oq = 32'h0000_0010;
        send_beat(mk_hdr(32'h1234_5678, 8'h10, 16'h0000), mk_user(8'h04, 8'h00), 1'b0, '1);
        send_beat({8{32'h0707_0707}}, mk_user(8'h04, 8'h00), 1'b1, '1);
        send_beat(mk_hdr(32'h8765_4321, 8'h10, 16'h0000), mk_user(8'h04, 8'h00), 1'b1, '1);
        check("t6_single_dst", m_if.tuser[31:24], 8'h08);
        idle(2);
        check_counts("t6");
        send_beat(mk_hdr(32'hFEED_0001, 8'h30, 16'h1111), mk_user(8'h01, 8'h00), 1'b0, '1);
        s_if.tvalid = 1'b0;
        rst = 1'b1;
        expq.delete();
        m_fwd = 0; m_miss = 0; m_ttl = 0; m_in_pkt = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rst_valid", m_if.tvalid, 1'b0);
        check("t6_rst_fwd",   fwd_cnt, 32'd0);
        rst = 1'b0;
        idle(1);
        send_beat(mk_hdr(32'hFEED_0002, 8'h30, 16'h2222), mk_user(8'h01, 8'h00), 1'b0, '1);
        check("t6_after_rst_ttl", m_if.tdata[79:72], 8'h2F);
        send_beat({8{32'h0808_0808}}, mk_user(8'h01, 8'h00), 1'b1, '1);
        idle(2);
        check("t6_after_rst_fwd", fwd_cnt, 32'd1);
        check_counts("t6b");

        spins = 0;
        while (expq.size() != 0 && spins < 20) begin
            @(posedge clk);
            spins++;
        end
        check("final_queue_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
